// File: rtl/fp16_pkg.sv
// Shared constants, operand classes and the unpack/classify helper for the
// binary16 multiplier.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;
  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

  // Subnormals (exp == 0, fraction != 0) are treated as zero on input.
  function automatic fp_class_e classify(input logic [15:0] x);
    fp_class_e c;
    case (x[14:10])
      5'd0:    c = ZERO;
      5'd31:   c = (x[9:0] == 10'd0) ? INF : NAN;
      default: c = NORMAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fp16_norm_round.sv
// Combinational normalize, round-to-nearest-even and range check of a
// normal-path product, packed as fp16.
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic signed [6:0] exp_in,
  input  logic [21:0]       prod,
  output logic [15:0]       result
);

  logic              hi;
  logic [10:0]       kept;
  logic              guard;
  logic              sticky;
  logic              rnd;
  logic [11:0]       rsum;
  logic signed [6:0] exp_norm;
  logic signed [6:0] exp_fin;
  logic [9:0]        frac;

  // Normalize the product, round, and resolve overflow/underflow.
  always_comb begin
    hi       = prod[21];
    kept     = 11'd0;
    guard    = 1'b0;
    sticky   = 1'b0;
    exp_fin  = 7'sd0;
    frac     = 10'd0;
    result   = 16'h0000;
    if (hi) begin
      kept   = prod[21:11];
      guard  = prod[10];
      sticky = |prod[9:0];
    end else begin
      kept   = prod[20:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    exp_norm = exp_in + $signed({6'b000000, hi});
    rnd      = guard & (sticky | kept[0]);
    rsum     = {1'b0, kept} + {11'd0, rnd};
    // A carry out of the 11-bit significand leaves 1.000... at the next exponent.
    if (rsum[11]) begin
      exp_fin = exp_norm + 7'sd1;
      frac    = 10'd0;
    end else begin
      exp_fin = exp_norm;
      frac    = rsum[9:0];
    end
    if (exp_fin >= 7'sd31) begin
      result = {sign, 5'h1F, 10'h000};
    end else if (exp_fin <= 7'sd0) begin
      result = {sign, 15'h0000};
    end else begin
      result = {sign, exp_fin[4:0], frac};
    end
  end

endmodule

// File: rtl/fp16_multiplier.sv
// Two-stage pipelined fp16 multiplier: stage 1 classifies and multiplies,
// stage 2 normalizes, rounds and packs into the registered output.
module fp16_multiplier
  import fp16_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] out
);

  fp_class_e         cls_a;
  fp_class_e         cls_b;
  fp_class_e         cls_next;
  logic              sign_next;
  logic signed [6:0] exp_next;
  logic [21:0]       prod_next;

  fp_class_e         cls_q;
  logic              sign_q;
  logic signed [6:0] exp_q;
  logic [21:0]       prod_q;

  logic [15:0]       norm_result;
  logic [15:0]       out_next;

  // Stage-1 operand classification, exponent sum and significand product.
  always_comb begin
    cls_a     = classify(A);
    cls_b     = classify(B);
    sign_next = A[15] ^ B[15];
    exp_next  = $signed({2'b00, A[14:10]}) + $signed({2'b00, B[14:10]}) - 7'sd15;
    prod_next = {11'd0, 1'b1, A[9:0]} * {11'd0, 1'b1, B[9:0]};
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
      cls_next = NAN;
    end else if (cls_a == INF || cls_b == INF) begin
      cls_next = INF;
    end else if (cls_a == ZERO || cls_b == ZERO) begin
      cls_next = ZERO;
    end else begin
      cls_next = NORMAL;
    end
  end

  fp16_norm_round u_norm_round (
    .sign   (sign_q),
    .exp_in (exp_q),
    .prod   (prod_q),
    .result (norm_result)
  );

  // Stage-2 selection between special results and the rounded normal product.
  always_comb begin
    out_next = 16'h0000;
    case (cls_q)
      NAN:     out_next = QNAN;
      INF:     out_next = {sign_q, 5'h1F, 10'h000};
      ZERO:    out_next = {sign_q, 15'h0000};
      NORMAL:  out_next = norm_result;
      default: out_next = 16'h0000;
    endcase
  end

  // Pipeline registers; the reset class ZERO with sign 0 keeps out at 0 while flushing.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      cls_q  <= ZERO;
      sign_q <= 1'b0;
      exp_q  <= 7'sd0;
      prod_q <= 22'd0;
      out    <= 16'h0000;
    end else begin
      cls_q  <= cls_next;
      sign_q <= sign_next;
      exp_q  <= exp_next;
      prod_q <= prod_next;
      out    <= out_next;
    end
  end

endmodule

// File: tb/tb_fp16_multiplier.sv
// Directed self-checking bench for fp16_multiplier with hand-computed products.
module tb_fp16_multiplier;

  logic        CLK;
  logic        RESETn;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] out;

  int checks;
  int errors;

  logic [15:0] va [0:5];
  logic [15:0] vb [0:5];
  logic [15:0] ve [0:5];

  fp16_multiplier dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .A      (A),
    .B      (B),
    .out    (out)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] expv);
    checks++;
    assert (out === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, out, expv);
    end
  endtask

  // One pair per 200 ns: apply, wait two rising edges, check, then hold.
  task automatic product(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] expv);
    @(negedge CLK);
    A = a;
    B = b;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check(tag, expv);
    repeat (8) @(posedge CLK);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESETn = 1'b0;
    A = 16'hD5C7;
    B = 16'h528F;

    // Reset held for 50 ns with operands present.
    @(posedge CLK); #1; check("reset_0", 16'h0000);
    @(posedge CLK); #1; check("reset_1", 16'h0000);
    #30;
    check("reset_2", 16'h0000);

    // Release: first product at the second rising edge.
    @(negedge CLK);
    RESETn = 1'b1;
    A = 16'h4E6E;
    B = 16'h5502;
    @(posedge CLK); #1; check("release_edge1", 16'h0000);
    @(posedge CLK); #1; check("release_edge2", 16'h6806);

    product("round_up",    16'hD5C7, 16'h528F, 16'hECBD);
    product("norm_shift",  16'h4E6E, 16'h5502, 16'h6806);
    product("mixed_sign",  16'h54C7, 16'hC366, 16'hDC6B);
    product("noshift_up",  16'h488B, 16'hD006, 16'hDC92);
    product("identity",    16'h3C00, 16'h4500, 16'h4500);
    product("neg_one",     16'hBC00, 16'h3C00, 16'hBC00);
    product("overflow",    16'h7BFF, 16'h7BFF, 16'h7C00);
    product("underflow",   16'h0400, 16'h0400, 16'h0000);
    product("underflow_n", 16'h8400, 16'h0400, 16'h8000);
    product("inf_x_zero",  16'h7C00, 16'h0000, 16'h7E00);
    product("nan_in",      16'h7E01, 16'h3C00, 16'h7E00);
    product("neg_inf",     16'hFC00, 16'h4000, 16'hFC00);
    product("zero_sign",   16'h0000, 16'hD5C7, 16'h8000);
    product("subnormal",   16'h0001, 16'h3C00, 16'h0000);

    // Back-to-back pairs, one per cycle; check results in order.
    va[0] = 16'hD5C7; vb[0] = 16'h528F; ve[0] = 16'hECBD;
    va[1] = 16'h4E6E; vb[1] = 16'h5502; ve[1] = 16'h6806;
    va[2] = 16'h54C7; vb[2] = 16'hC366; ve[2] = 16'hDC6B;
    va[3] = 16'h488B; vb[3] = 16'hD006; ve[3] = 16'hDC92;
    va[4] = 16'h7BFF; vb[4] = 16'h7BFF; ve[4] = 16'h7C00;
    va[5] = 16'hBC00; vb[5] = 16'h3C00; ve[5] = 16'hBC00;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i >= 2) check($sformatf("stream_%0d", i - 2), ve[i - 2]);
      if (i < 6) begin
        A = va[i];
        B = vb[i];
      end else begin
        A = 16'h3C00;
        B = 16'h4500;
      end
    end

    // Mid-stream reset: in-flight products are discarded.
    @(negedge CLK);
    check("pre_midreset", 16'h4500);
    A = 16'h488B;
    B = 16'hD006;
    RESETn = 1'b0;
    @(posedge CLK); #1; check("midreset_edge1", 16'h0000);
    @(negedge CLK);
    RESETn = 1'b1;
    A = 16'hD5C7;
    B = 16'h528F;
    @(posedge CLK); #1; check("midreset_flush", 16'h0000);
    @(posedge CLK); #1; check("midreset_resume", 16'hECBD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_multiplier.md
# fp16_multiplier

Pipelined IEEE-754 binary16 (half-precision) multiplier, the multiply stage of the floating-point MAC datapath. It takes two fp16 operands every clock and produces their rounded product two clocks later. It has no handshake; the output continuously reflects the operand pair sampled two edges earlier.

## Interface
- Parameters: none. Format fixed at 1 sign, 5 exponent (bias 15), 10 fraction bits.
- CLK  in  1  rising-edge clock.
- RESETn  in  1  reset, synchronous and active-low.
- A  in  16  fp16 multiplicand.
- B  in  16  fp16 multiplier.
- out  out  16  fp16 product A×B, registered.

## Operation
- Sign = A[15] ^ B[15], for every result including zeros and infinities.
- Unpack each operand:
  - exp = x[14:10]; sig = {1, x[9:0]} for a normal operand.
  - exp = 0 is zero. Subnormal inputs flush to zero.
  - exp = 31 is infinity if the fraction is 0, otherwise NaN.
- Specials, in priority order:
  - Any NaN, or inf×0: out = 16'h7E00, canonical quiet NaN, sign ignored.
  - Any inf: out = {sign, 5'h1F, 10'h0}.
  - Any zero: out = {sign, 15'h0}.
- Normal path:
  - 11×11 significand product P, 22 bits, value range [1, 4).
  - Exponent E = eA + eB − 15, computed signed with at least 7 bits.
  - If P[21] = 1: E += 1, kept significand = P[21:11], guard = P[10], sticky = |P[9:0].
  - Otherwise: kept significand = P[20:10], guard = P[9], sticky = |P[8:0].
- Rounding is round-to-nearest-even: increment if guard & (sticky | lsb).
  - If rounding carries out to 2048: significand = 1024, E += 1.
- Range:
  - E ≥ 31 after rounding: ±inf, 16'h7C00 | sign.
  - E ≤ 0: flush to signed zero. No subnormal outputs.
- Otherwise out = {sign, E[4:0], significand[9:0]}.

## Timing
- Stage 1 at edge k: register sign, special-case class, E, and P.
- Stage 2 at edge k+1: normalize, round, pack into out.
- Latency 2 cycles, throughput 1 per cycle. out changes only on rising edges.
- RESETn low at an edge clears all pipeline registers and out to 16'h0000.
  - out stays 0 until two edges after RESETn returns high.
  - Reset mid-operation discards in-flight operands.
- A and B are sampled every edge, whether or not they have changed.

## Structure
- Package fp16_pkg holds:
  - constants EXP_W = 5, FRAC_W = 10, BIAS = 15, EXP_MAX = 31, QNAN = 16'h7E00;
  - the operand-class enum {ZERO, NORMAL, INF, NAN}.
- One sub-module is natural: fp16_norm_round. It is combinational and covers P/E → normalized, rounded, range-checked packed result.
- The top module holds unpack/classify, the multiplier, and both pipeline register stages.

## Test plan
- Directed products, each checked two edges after applying the pair, with one pair every 200 ns:
  - 0xD5C7 × 0x528F → 0xECBD (−92.4375 × 52.46875, rounds up).
  - 0x4E6E × 0x5502 → 0x6806 (normalize shift, rounds down).
  - 0x54C7 × 0xC366 → 0xDC6B.
  - 0x488B × 0xD006 → 0xDC92 (no shift, rounds up).
- Identity and exactness: 0x3C00 × 0x4500 → 0x4500, and 0xBC00 × 0x3C00 → 0xBC00.
- Overflow and underflow:
  - 0x7BFF × 0x7BFF → 0x7C00.
  - 0x0400 × 0x0400 → 0x0000.
  - 0x8400 × 0x0400 → 0x8000.
- Specials:
  - 0x7C00 × 0x0000 → 0x7E00.
  - 0x7E01 × 0x3C00 → 0x7E00.
  - 0xFC00 × 0x4000 → 0xFC00.
  - 0x0000 × 0xD5C7 → 0x8000.
  - Subnormal 0x0001 × 0x3C00 → 0x0000.
- Reset and pipeline:
  - RESETn low for 50 ns with operands applied → out = 0x0000 throughout.
  - After release, first product appears at the second rising edge.
  - Back-to-back distinct pairs on consecutive cycles → results emerge in order at one per cycle.
  - Asserting RESETn mid-stream → out = 0x0000 on the next edge.
